// File: rtl/module_display_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK_DEFAULT = 7'b1111111;

  // Widest supported display; instances slice the low N_DIGITS bits.
  localparam logic [7:0] AN_ALL_OFF = 8'hFF;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/module_display_scan_bcd_decoder.sv
// BCD nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Codes above 9 yield an all-off pattern; the caller applies its own blanking.
module module_bcd_decoder
  import display_pkg::*;
(
  input  logic [3:0] w,
  output seg_t       bcd
);

  always_comb begin
    unique case (w)
      4'd0:    bcd = 7'b1000000;
      4'd1:    bcd = 7'b1111001;
      4'd2:    bcd = 7'b0100100;
      4'd3:    bcd = 7'b0110000;
      4'd4:    bcd = 7'b0011001;
      4'd5:    bcd = 7'b0010010;
      4'd6:    bcd = 7'b0000010;
      4'd7:    bcd = 7'b1111000;
      4'd8:    bcd = 7'b0000000;
      4'd9:    bcd = 7'b0010000;
      default: bcd = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/module_display_scan.sv
// Time-multiplexed common-anode 7-segment driver with a frame-synchronous
// double buffer, dead time between digits and optional leading-zero blanking.
module module_display_scan
  import display_pkg::*;
#(
  parameter int   N_DIGITS    = 4,
  parameter int   REFRESH_DIV = 27000,
  parameter int   DEAD_CYCLES = 2,
  parameter seg_t SEG_BLANK   = SEG_BLANK_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic                  load_i,
  input  logic                  lz_blank_i,
  output logic [6:0]            seg_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  frame_o,
  output logic                  busy_o
);

  localparam int IW = idx_width(N_DIGITS);
  localparam int PW = idx_width(REFRESH_DIV);
  localparam logic [N_DIGITS-1:0] AN_OFF = AN_ALL_OFF[N_DIGITS-1:0];

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] pending;
  logic [4*N_DIGITS-1:0] display;

  logic                  tick;
  logic                  wrap;
  logic [3:0]            nib;
  seg_t                  dec_seg;
  logic [N_DIGITS-1:0]   zero_from;
  logic                  zero_acc;
  seg_t                  seg_nxt;
  logic [N_DIGITS-1:0]   an_nxt;

  assign tick = (presc == PW'(REFRESH_DIV - 1));
  assign wrap = tick && (idx == IW'(N_DIGITS - 1));
  assign nib  = display[{idx, 2'b00} +: 4];

  module_bcd_decoder u_dec (
    .w   (nib),
    .bcd (dec_seg)
  );

  // zero_from[k] is set when digit k and every digit above it hold zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    zero_from = '0;
    zero_acc  = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_acc     = zero_acc && (display[4*k +: 4] == 4'd0);
      zero_from[k] = zero_acc;
    end
  end

  always_comb begin
    seg_nxt = SEG_BLANK;
    an_nxt  = AN_OFF;
    if (int'(presc) >= DEAD_CYCLES) begin
      an_nxt[idx] = 1'b0;
      if (nib > 4'd9) begin
        seg_nxt = SEG_BLANK;
      end else if (lz_blank_i && (idx != '0) && zero_from[idx]) begin
        seg_nxt = SEG_BLANK;
      end else begin
        seg_nxt = dec_seg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the buffers are a handful of flops, not a RAM, so they take the reset like the rest.
      presc   <= '0;
      idx     <= '0;
      pending <= '0;
      display <= '0;
      seg_o   <= SEG_BLANK;
      an_o    <= AN_OFF;
      frame_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      presc   <= tick ? '0 : presc + 1'b1;
      frame_o <= wrap;
      seg_o   <= seg_nxt;
      an_o    <= an_nxt;
      if (tick) begin
        idx <= wrap ? '0 : idx + 1'b1;
      end
      if (wrap) begin
        display <= pending;
        busy_o  <= 1'b0;
      end
      // A load on the wrap edge overrides the clear above and lands in the next frame.
      if (load_i) begin
        pending <= digits_i;
        busy_o  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_module_display_scan.sv
// Randomized and directed bench for module_display_scan; the reference model
// derives slot, digit and frame position from an edge count since reset.
module tb_module_display_scan;

  localparam int N = 4;
  localparam int R = 4;
  localparam int D = 1;
  localparam int FRAME = N * R;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   digits_i;
  logic          load_i;
  logic          lz_blank_i;
  logic [6:0]    seg_o;
  logic [N-1:0]  an_o;
  logic          frame_o;
  logic          busy_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_edges;
  logic [15:0] m_pend;
  logic [15:0] m_disp;
  logic        m_busy;
  logic        m_frame;
  logic [6:0]  m_seg;
  logic [N-1:0] m_an;
  logic [6:0]  seg_tab [10];

  module_display_scan #(
    .N_DIGITS    (N),
    .REFRESH_DIV (R),
    .DEAD_CYCLES (D),
    .SEG_BLANK   (7'b1111111)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_i   (digits_i),
    .load_i     (load_i),
    .lz_blank_i (lz_blank_i),
    .seg_o      (seg_o),
    .an_o       (an_o),
    .frame_o    (frame_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Expected outputs for the cycle where the scan sits at slot phase p of digit k.
  task automatic model_outputs(input int p, input int k, input logic lz);
    logic [3:0]  n4;
    logic [15:0] upper;
    m_seg = 7'b1111111;
    m_an  = '1;
    if (p >= D) begin
      m_an[k] = 1'b0;
      n4    = 4'((m_disp >> (4 * k)) & 16'hF);
      upper = m_disp >> (4 * k);
      if (n4 > 4'd9)                           m_seg = 7'b1111111;
      else if (lz && k != 0 && upper == 16'd0) m_seg = 7'b1111111;
      else                                     m_seg = seg_tab[n4];
    end
  endtask

  // One clock: apply inputs, advance the model across the edge, compare just after it.
  task automatic step(input logic ld, input logic [15:0] d, input logic lz, input logic rst);
    load_i     = ld;
    digits_i   = d;
    lz_blank_i = lz;
    rst_n      = rst;
    @(posedge clk);
    if (!rst) begin
      m_edges = 0;
      m_pend  = '0;
      m_disp  = '0;
      m_busy  = 1'b0;
      m_frame = 1'b0;
      m_seg   = 7'b1111111;
      m_an    = '1;
    end else begin
      model_outputs(m_edges % R, (m_edges / R) % N, lz);
      m_edges++;
      m_frame = (m_edges % FRAME) == 0;
      if (m_frame) begin
        m_disp = m_pend;
        m_busy = 1'b0;
      end
      if (ld) begin
        m_pend = d;
        m_busy = 1'b1;
      end
    end
    #1;
    check("seg",   32'(seg_o),   32'(m_seg));
    check("an",    32'(an_o),    32'(m_an));
    check("frame", 32'(frame_o), 32'(m_frame));
    check("busy",  32'(busy_o),  32'(m_busy));
  endtask

  task automatic idle(input int cycles, input logic lz);
    for (int i = 0; i < cycles; i++) step(1'b0, 16'h0, lz, 1'b1);
  endtask

  // Run until the next edge taken is the one at frame position pos.
  task automatic run_to(input int pos, input logic lz);
    for (int i = 0; i < FRAME && ((m_edges + 1) % FRAME) != pos; i++) step(1'b0, 16'h0, lz, 1'b1);
  endtask

  initial begin
    int first_frame;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    m_edges = 0;
    m_pend = '0; m_disp = '0; m_busy = 1'b0; m_frame = 1'b0;
    rst_n = 1'b0; load_i = 1'b0; digits_i = '0; lz_blank_i = 1'b0;

    // Reset held with load toggling
    for (int i = 0; i < 3; i++) step(1'(i % 2 == 0), 16'hBEEF, 1'b0, 1'b0);

    // First frame pulse after release, bounded search
    first_frame = -1;
    for (int i = 1; i <= 40 && first_frame < 0; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b1);
      if (frame_o) first_frame = i;
    end
    check("first_frame_cycle", 32'(first_frame), 32'd16);

    // Basic scan: load then two full frames after latch
    step(1'b1, 16'h1234, 1'b0, 1'b1);
    run_to(0, 1'b0);
    idle(2 * FRAME, 1'b0);

    // Mid-frame load while 1234 is shown
    run_to(6, 1'b0);
    step(1'b1, 16'h5678, 1'b0, 1'b1);
    check("busy_midframe", 32'(busy_o), 32'd1);
    idle(2 * FRAME, 1'b0);

    // Load exactly on the wrap edge
    run_to(0, 1'b0);
    step(1'b1, 16'h0009, 1'b0, 1'b1);
    check("busy_on_wrap_load", 32'(busy_o), 32'd1);
    idle(2 * FRAME, 1'b0);

    // Leading-zero blanking
    step(1'b1, 16'h0009, 1'b1, 1'b1);
    idle(2 * FRAME, 1'b1);
    step(1'b1, 16'h0000, 1'b1, 1'b1);
    idle(2 * FRAME, 1'b1);
    step(1'b1, 16'h0100, 1'b1, 1'b1);
    idle(2 * FRAME, 1'b1);

    // Invalid nibbles, then reset mid-slot with a pending load outstanding
    step(1'b1, 16'hA1F2, 1'b0, 1'b1);
    idle(2 * FRAME, 1'b0);
    step(1'b1, 16'h4321, 1'b0, 1'b1);
    run_to(7, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    check("reset_drops_busy", 32'(busy_o), 32'd0);
    idle(2 * FRAME, 1'b0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 7) == 0), 16'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 199) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
